// File: rtl/pe_array_sequencer.sv
// Sequences PE_array control for a multi-column pass: clear, select column, fetch operands,
// then step Sel_cu / Sel_cu_go_back / Sel_adder, drain, and report done.
module pe_array_sequencer #(
   parameter int unsigned STEP_GAP     = 1,
   parameter int unsigned DRAIN_CYCLES = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] cfg_sel_cu,
   input  logic [7:0] cfg_go_back,
   input  logic [7:0] cfg_adder,
   input  logic [1:0] cfg_sum_row,
   input  logic [1:0] cfg_sum_col,
   input  logic [2:0] cfg_last_col,
   output logic       buf_rd_req,
   output logic [2:0] buf_rd_col,
   input  logic       buf_rd_valid,
   output logic       load_en,
   output logic [2:0] Col_index,
   output logic [7:0] Sel_cu,
   output logic [7:0] Sel_cu_go_back,
   output logic [7:0] Sel_adder,
   output logic [1:0] Sum_row_pe,
   output logic [1:0] Sum_column_pe,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CNT_MAX = (STEP_GAP > DRAIN_CYCLES) ? STEP_GAP : DRAIN_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   // LDEN is the single cycle after buf_rd_valid is seen, carrying the registered load_en strobe.
   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_CLR   = 4'd1,
      ST_SEL   = 4'd2,
      ST_LOAD  = 4'd3,
      ST_LDEN  = 4'd4,
      ST_CU    = 4'd5,
      ST_GB    = 4'd6,
      ST_ADD   = 4'd7,
      ST_DRAIN = 4'd8,
      ST_DONE  = 4'd9
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;
   logic [2:0]       col;
   logic [7:0]       cfg_cu_q, cfg_gb_q, cfg_ad_q;
   logic [2:0]       cfg_last_q;

   logic       buf_rd_req_nxt, load_en_nxt, busy_nxt, done_nxt;
   logic [2:0] buf_rd_col_nxt, col_index_nxt;
   logic [7:0] sel_cu_nxt, sel_gb_nxt, sel_ad_nxt;
   logic [1:0] sum_row_nxt, sum_col_nxt;

   assign cnt_zero = (cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_CLR;
         ST_CLR:   state_nxt = ST_SEL;
         ST_SEL:   state_nxt = ST_LOAD;
         ST_LOAD:  if (buf_rd_valid) state_nxt = ST_LDEN;
         ST_LDEN:  state_nxt = ST_CU;
         ST_CU:    if (cnt_zero) state_nxt = ST_GB;
         ST_GB:    if (cnt_zero) state_nxt = ST_ADD;
         ST_ADD:   if (cnt_zero) state_nxt = (col == cfg_last_q) ? ST_DRAIN : ST_CLR;
         ST_DRAIN: if (cnt_zero) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Step counter reloads on every state change; config captured on start acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         col        <= '0;
         cfg_cu_q   <= '0;
         cfg_gb_q   <= '0;
         cfg_ad_q   <= '0;
         cfg_last_q <= '0;
      end else begin
         if (state_nxt != state)
            cnt <= (state_nxt == ST_DRAIN) ? CNT_W'(DRAIN_CYCLES - 1) : CNT_W'(STEP_GAP - 1);
         else if (!cnt_zero)
            cnt <= cnt - CNT_W'(1);
         if (state == ST_IDLE && start) begin
            col        <= '0;
            cfg_cu_q   <= cfg_sel_cu;
            cfg_gb_q   <= cfg_go_back;
            cfg_ad_q   <= cfg_adder;
            cfg_last_q <= cfg_last_col;
         end else if (state == ST_ADD && cnt_zero && col != cfg_last_q) begin
            col <= col + 3'd1;
         end
      end
   end

   // Next output values keyed on the state being entered, so registered outputs align with state.
   always_comb begin
      buf_rd_req_nxt = buf_rd_req;
      buf_rd_col_nxt = buf_rd_col;
      load_en_nxt    = 1'b0;
      col_index_nxt  = Col_index;
      sel_cu_nxt     = Sel_cu;
      sel_gb_nxt     = Sel_cu_go_back;
      sel_ad_nxt     = Sel_adder;
      sum_row_nxt    = Sum_row_pe;
      sum_col_nxt    = Sum_column_pe;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      if (state == ST_IDLE && state_nxt == ST_CLR) begin
         busy_nxt    = 1'b1;
         sum_row_nxt = cfg_sum_row;
         sum_col_nxt = cfg_sum_col;
      end
      case (state_nxt)
         ST_IDLE: busy_nxt = 1'b0;
         ST_CLR: begin
            sel_cu_nxt = '0;
            sel_gb_nxt = '0;
            sel_ad_nxt = '0;
         end
         ST_SEL: col_index_nxt = col;
         ST_LOAD: begin
            buf_rd_req_nxt = 1'b1;
            buf_rd_col_nxt = col;
         end
         ST_LDEN: begin
            buf_rd_req_nxt = 1'b0;
            load_en_nxt    = 1'b1;
         end
         ST_CU:  sel_cu_nxt = cfg_cu_q;
         ST_GB:  sel_gb_nxt = cfg_gb_q;
         ST_ADD: sel_ad_nxt = cfg_ad_q;
         ST_DONE: begin
            done_nxt    = 1'b1;
            sel_cu_nxt  = '0;
            sel_gb_nxt  = '0;
            sel_ad_nxt  = '0;
            sum_row_nxt = '0;
            sum_col_nxt = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_rd_req     <= 1'b0;
         buf_rd_col     <= '0;
         load_en        <= 1'b0;
         Col_index      <= '0;
         Sel_cu         <= '0;
         Sel_cu_go_back <= '0;
         Sel_adder      <= '0;
         Sum_row_pe     <= '0;
         Sum_column_pe  <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         buf_rd_req     <= buf_rd_req_nxt;
         buf_rd_col     <= buf_rd_col_nxt;
         load_en        <= load_en_nxt;
         Col_index      <= col_index_nxt;
         Sel_cu         <= sel_cu_nxt;
         Sel_cu_go_back <= sel_gb_nxt;
         Sel_adder      <= sel_ad_nxt;
         Sum_row_pe     <= sum_row_nxt;
         Sum_column_pe  <= sum_col_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
      end
   end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: stimulus queues expected load_en/done events,
// a negedge monitor pops and compares them against the DUT.
module tb_pe_array_sequencer;

   localparam int DRAIN = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] cfg_sel_cu = '0, cfg_go_back = '0, cfg_adder = '0;
   logic [1:0] cfg_sum_row = '0, cfg_sum_col = '0;
   logic [2:0] cfg_last_col = '0;
   logic       buf_rd_valid = 1'b0;
   logic       buf_rd_req, load_en, busy, done;
   logic [2:0] buf_rd_col, Col_index;
   logic [7:0] Sel_cu, Sel_cu_go_back, Sel_adder;
   logic [1:0] Sum_row_pe, Sum_column_pe;

   pe_array_sequencer #(.STEP_GAP(1), .DRAIN_CYCLES(DRAIN)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_sel_cu(cfg_sel_cu), .cfg_go_back(cfg_go_back), .cfg_adder(cfg_adder),
      .cfg_sum_row(cfg_sum_row), .cfg_sum_col(cfg_sum_col), .cfg_last_col(cfg_last_col),
      .buf_rd_req(buf_rd_req), .buf_rd_col(buf_rd_col), .buf_rd_valid(buf_rd_valid),
      .load_en(load_en), .Col_index(Col_index), .Sel_cu(Sel_cu),
      .Sel_cu_go_back(Sel_cu_go_back), .Sel_adder(Sel_adder),
      .Sum_row_pe(Sum_row_pe), .Sum_column_pe(Sum_column_pe), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_done;
      int         col;
      int         off;
      int         wait_c;
      logic [7:0] cu, gb, ad;
      logic [1:0] sr, sc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   t_start = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   dly[8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Operand buffer: valid appears in the dly[col]-th cycle of an outstanding request.
   int rq_cnt = 0;
   always @(negedge clk) begin
      if (!rst || !buf_rd_req) begin
         rq_cnt       = 0;
         buf_rd_valid = 1'b0;
      end else begin
         rq_cnt++;
         buf_rd_valid = (rq_cnt >= dly[buf_rd_col]);
      end
   end

   logic [7:0] p_cu = '0, p_gb = '0, p_ad = '0;
   int         m_req = 0;
   exp_t       e_m;
   always @(negedge clk) begin
      if (!rst) begin
         m_req = 0;
      end else begin
         if (buf_rd_req) begin
            m_req++;
            chk("sel_zero_in_load", {8'd0, Sel_cu, Sel_cu_go_back, Sel_adder}, 32'd0);
         end
         if (load_en || done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", {30'd0, load_en, done}, 32'd0);
            end else begin
               e_m = exp_q.pop_front();
               chk("event_kind", {31'd0, done}, {31'd0, e_m.is_done});
               chk("event_cycle", cyc - t_start, e_m.off);
               if (done) begin
                  chk("drain_sel_held", {8'd0, p_cu, p_gb, p_ad}, {8'd0, e_m.cu, e_m.gb, e_m.ad});
                  chk("done_clears", {4'd0, Sel_cu, Sel_cu_go_back, Sel_adder, Sum_row_pe, Sum_column_pe}, 32'd0);
               end else begin
                  chk("col_index", {29'd0, Col_index}, e_m.col);
                  chk("buf_rd_col", {29'd0, buf_rd_col}, e_m.col);
                  chk("req_cycles", m_req, e_m.wait_c);
                  chk("req_dropped", {31'd0, buf_rd_req}, 32'd0);
                  chk("clr_between_cols", {8'd0, Sel_cu, Sel_cu_go_back, Sel_adder}, 32'd0);
                  chk("sum_modes", {28'd0, Sum_row_pe, Sum_column_pe}, {28'd0, e_m.sr, e_m.sc});
               end
            end
         end
         if (load_en) m_req = 0;
      end
      p_cu = Sel_cu;
      p_gb = Sel_cu_go_back;
      p_ad = Sel_adder;
   end

   // Column k takes 6 + dly[k] cycles; load_en lands 2 + dly[k] cycles into its column.
   task automatic start_pass(input int last, input logic [7:0] cu, gb, ad, input logic [1:0] sr, sc);
      int   off;
      exp_t e;
      off = 0;
      for (int k = 0; k <= last; k++) begin
         e = '{1'b0, k, off + 2 + dly[k], dly[k], cu, gb, ad, sr, sc};
         exp_q.push_back(e);
         off += 6 + dly[k];
      end
      e = '{1'b1, 0, off + DRAIN, 0, cu, gb, ad, sr, sc};
      exp_q.push_back(e);
      @(negedge clk);
      cfg_sel_cu = cu; cfg_go_back = gb; cfg_adder = ad;
      cfg_sum_row = sr; cfg_sum_col = sc; cfg_last_col = 3'(last);
      start = 1'b1;
      @(posedge clk);
      #1 t_start = cyc;
      @(negedge clk);
      start = 1'b0;
      cfg_sel_cu = ~cu; cfg_go_back = ~gb; cfg_adder = ~ad;
      cfg_sum_row = ~sr; cfg_sum_col = ~sc; cfg_last_col = ~3'(last);
   endtask

   task automatic wait_done(input bit poke);
      bit got, poked;
      got = 1'b0;
      poked = 1'b0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (poke && !poked && Sel_cu != 8'd0 && Sel_cu_go_back == 8'd0) begin
            start = 1'b1;
            poked = 1'b1;
         end
         if (done) begin
            got = 1'b1;
            if (poke) start = 1'b1;
         end
      end
      chk("done_seen", {31'd0, got}, 32'd1);
      @(negedge clk);
      start = 1'b0;
      chk("busy_low_after_done", {30'd0, busy, done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("stays_idle", {29'd0, busy, buf_rd_req, load_en}, 32'd0);
   endtask

   initial begin
      bit found;
      for (int k = 0; k < 8; k++) dly[k] = 1;
      repeat (2) @(negedge clk);
      chk("reset_sel", {8'd0, Sel_cu, Sel_cu_go_back, Sel_adder}, 32'd0);
      chk("reset_ctrl", {18'd0, buf_rd_req, buf_rd_col, load_en, Col_index, Sum_row_pe, Sum_column_pe, busy, done}, 32'd0);
      rst = 1'b1;

      // Abort while column 3 waits on the buffer.
      dly[3] = 100;
      start_pass(7, 8'hFF, 8'hAA, 8'h55, 2'b01, 2'b10);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (buf_rd_req && buf_rd_col == 3'd3) found = 1'b1;
      end
      chk("reach_col3_load", {31'd0, found}, 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("abort_sel", {8'd0, Sel_cu, Sel_cu_go_back, Sel_adder}, 32'd0);
      chk("abort_ctrl", {18'd0, buf_rd_req, buf_rd_col, load_en, Col_index, Sum_row_pe, Sum_column_pe, busy, done}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      dly[3] = 1;

      // Single column restart after abort.
      start_pass(0, 8'b10101010, 8'h0F, 8'hF0, 2'b11, 2'b01);
      wait_done(1'b0);

      // Full eight-column pass with the buffer always ready.
      start_pass(7, 8'b11111111, 8'b10101010, 8'b01010101, 2'b01, 2'b10);
      wait_done(1'b0);

      // Slow buffer on column 2, stray starts during CU and DONE, cfg scrambled mid-pass.
      dly[2] = 5;
      start_pass(3, 8'h3C, 8'hC3, 8'h81, 2'b10, 2'b11);
      wait_done(1'b1);

      chk("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
